// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle for alu_exec_unit.
// Overflow exists only when ALU_OVF_TRAP_EN is defined.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [1:0]       ALUOp;
  logic [5:0]       FuncCode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic [3:0]       ALUctl;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
`ifdef ALU_OVF_TRAP_EN
  logic             Overflow;
`endif

  modport master (
    output InValid, ALUOp, FuncCode, A, B, OutReady,
`ifdef ALU_OVF_TRAP_EN
    input  Overflow,
`endif
    input  InReady, OutValid, Result, Zero, ALUctl, Hi, Lo
  );

  modport slave (
    input  InValid, ALUOp, FuncCode, A, B, OutReady,
`ifdef ALU_OVF_TRAP_EN
    output Overflow,
`endif
    output InReady, OutValid, Result, Zero, ALUctl, Hi, Lo
  );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS execute unit: ALUOp/funct decode, single-cycle ALU, iterative multu with HI/LO.
// Define ALU_OVF_TRAP_EN to add the Overflow output (signed add/sub overflow, illegal op).
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            Clk,
  input  logic            Reset,
  alu_exec_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_MULTU = 4'b1000;
  localparam logic [3:0] CTL_MFHI  = 4'b1001;
  localparam logic [3:0] CTL_MFLO  = 4'b1010;
  localparam logic [3:0] CTL_NOR   = 4'b1100;
  localparam logic [3:0] CTL_ILL   = 4'b1111;

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'b00:   return CTL_ADD;
      2'b01:   return CTL_SUB;
      2'b10: begin
        case (fn)
          6'b100000: return CTL_ADD;
          6'b100010: return CTL_SUB;
          6'b100100: return CTL_AND;
          6'b100101: return CTL_OR;
          6'b100111: return CTL_NOR;
          6'b101010: return CTL_SLT;
          6'b011001: return CTL_MULTU;
          6'b010000: return CTL_MFHI;
          6'b010010: return CTL_MFLO;
          default:   return CTL_ILL;
        endcase
      end
      default: return CTL_ILL;
    endcase
  endfunction

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic [3:0]         ctl_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [3:0]         ctl_d;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] prod_step;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ctl_d   = decode(bus.ALUOp, bus.FuncCode);
    sum     = bus.A + bus.B;
    diff    = bus.A - bus.B;
    alu_res = '0;
    case (ctl_d)
      CTL_ADD:  alu_res = sum;
      CTL_SUB:  alu_res = diff;
      CTL_AND:  alu_res = bus.A & bus.B;
      CTL_OR:   alu_res = bus.A | bus.B;
      CTL_NOR:  alu_res = ~(bus.A | bus.B);
      CTL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      CTL_MFHI: alu_res = hi_q;
      CTL_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  // Shift-add step: low half of prod_q holds the remaining multiplier bits.
  always_comb begin
    madd      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {madd, prod_q[WIDTH-1:1]};
  end

`ifdef ALU_OVF_TRAP_EN
  logic ovf_d;
  logic ovf_q;

  always_comb begin
    case (ctl_d)
      CTL_ADD: ovf_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      CTL_SUB: ovf_d = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      CTL_ILL: ovf_d = 1'b1;
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && bus.InValid) begin
      ovf_q <= ovf_d;
    end else if (state_q == MUL && cnt_q == CNT_W'(WIDTH)) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.Overflow = ovf_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ctl_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.InValid) begin
            ctl_q      <= ctl_d;
            in_ready_q <= 1'b0;
            if (ctl_d == CTL_MULTU) begin
              mcand_q <= bus.A;
              prod_q  <= {{WIDTH{1'b0}}, bus.B};
              cnt_q   <= '0;
              state_q <= MUL;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        MUL: begin
          // WIDTH step cycles, then one cycle to publish the product.
          if (cnt_q == CNT_W'(WIDTH)) begin
            hi_q        <= prod_q[2*WIDTH-1:WIDTH];
            lo_q        <= prod_q[WIDTH-1:0];
            result_q    <= prod_q[WIDTH-1:0];
            zero_q      <= (prod_q[WIDTH-1:0] == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = out_valid_q;
  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.ALUctl   = ctl_q;
  assign bus.Hi       = hi_q;
  assign bus.Lo       = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: vector table plus multu,
// backpressure and reset-abort sequences. Overflow checks need ALU_OVF_TRAP_EN.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic [3:0]   ctl;
    logic         ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.InReady !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("inready_wait", (n < 100), 1);
  endtask

  // Presents one op at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    bus.InValid  = 1'b1;
    bus.ALUOp    = op;
    bus.FuncCode = fn;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    @(negedge clk);
    bus.InValid  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bus.OutReady = 1'b1;
    send(v.op, v.fn, v.a, v.b);
    check({tag, "_outvalid"}, bus.OutValid, 1);
    check({tag, "_result"},   bus.Result,   v.res);
    check({tag, "_zero"},     bus.Zero,     v.z);
    check({tag, "_aluctl"},   bus.ALUctl,   v.ctl);
`ifdef ALU_OVF_TRAP_EN
    check({tag, "_overflow"}, bus.Overflow, v.ovf);
`endif
    @(posedge clk);
    @(negedge clk);
    check({tag, "_inready_after"},  bus.InReady,  1);
    check({tag, "_outvalid_after"}, bus.OutValid, 0);
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string tag);
    int   cyc = 0;
    logic saw_ready = 1'b0;
    bus.OutReady = 1'b1;
    send(2'b10, 6'b011001, a, b);
    while (bus.OutValid !== 1'b1 && cyc < 60) begin
      if (bus.InReady === 1'b1) saw_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"},     cyc,        33);
    check({tag, "_inready_low"}, saw_ready,  0);
    check({tag, "_result"},      bus.Result, exp_lo);
    check({tag, "_hi"},          bus.Hi,     exp_hi);
    check({tag, "_lo"},          bus.Lo,     exp_lo);
    check({tag, "_aluctl"},      bus.ALUctl, 4'b1000);
    check({tag, "_zero"},        bus.Zero,   (exp_lo == '0));
`ifdef ALU_OVF_TRAP_EN
    check({tag, "_overflow"},    bus.Overflow, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    check({tag, "_inready_after"}, bus.InReady, 1);
  endtask

  initial begin
    vec_t v;
    int   ovs;

    vecs[0]  = '{2'b10, 6'b100000, 32'd5,        32'd7,        32'd12,       1'b0, 4'b0010, 1'b0};
    vecs[1]  = '{2'b10, 6'b100010, 32'hFFFFFFF0, 32'h0000000F, 32'hFFFFFFE1, 1'b0, 4'b0110, 1'b0};
    vecs[2]  = '{2'b10, 6'b100100, 32'hFFFFFFF0, 32'h0000000F, 32'h00000000, 1'b1, 4'b0000, 1'b0};
    vecs[3]  = '{2'b10, 6'b100101, 32'hFFFFFFF0, 32'h0000000F, 32'hFFFFFFFF, 1'b0, 4'b0001, 1'b0};
    vecs[4]  = '{2'b10, 6'b101010, 32'hFFFFFFF0, 32'h0000000F, 32'h00000001, 1'b0, 4'b0111, 1'b0};
    vecs[5]  = '{2'b10, 6'b100111, 32'hFFFFFFF0, 32'h0000000F, 32'h00000000, 1'b1, 4'b1100, 1'b0};
    vecs[6]  = '{2'b10, 6'b101010, 32'd3,        32'd3,        32'h00000000, 1'b1, 4'b0111, 1'b0};
    vecs[7]  = '{2'b10, 6'b101010, 32'd5,        32'hFFFFFFFF, 32'h00000000, 1'b1, 4'b0111, 1'b0};
    vecs[8]  = '{2'b00, 6'b101010, 32'd3,        32'd4,        32'd7,        1'b0, 4'b0010, 1'b0};
    vecs[9]  = '{2'b01, 6'b100000, 32'd3,        32'd4,        32'hFFFFFFFF, 1'b0, 4'b0110, 1'b0};
    vecs[10] = '{2'b10, 6'b000000, 32'd9,        32'd9,        32'h00000000, 1'b1, 4'b1111, 1'b1};
    vecs[11] = '{2'b11, 6'b100000, 32'd9,        32'd9,        32'h00000000, 1'b1, 4'b1111, 1'b1};
    vecs[12] = '{2'b00, 6'b000000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 4'b0010, 1'b1};
    vecs[13] = '{2'b10, 6'b100010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 4'b0110, 1'b1};

    reset        = 1'b1;
    bus.InValid  = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.FuncCode = 6'b000000;
    bus.A        = '0;
    bus.B        = '0;
    bus.OutReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_inready",  bus.InReady,  1);
    check("rst_outvalid", bus.OutValid, 0);
    check("rst_result",   bus.Result,   0);
    check("rst_zero",     bus.Zero,     1);
    check("rst_aluctl",   bus.ALUctl,   0);
    check("rst_hi",       bus.Hi,       0);
    check("rst_lo",       bus.Lo,       0);
`ifdef ALU_OVF_TRAP_EN
    check("rst_overflow", bus.Overflow, 0);
`endif

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    check("hilo_untouched_hi", bus.Hi, 0);
    check("hilo_untouched_lo", bus.Lo, 0);

    run_mul(32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "mul1");
    v = '{2'b10, 6'b010000, 32'd0, 32'd0, 32'h00000001, 1'b0, 4'b1001, 1'b0};
    run_vec(v, "mfhi1");
    v = '{2'b10, 6'b010010, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 4'b1010, 1'b0};
    run_vec(v, "mflo1");

    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "mul2");
    v = '{2'b10, 6'b010000, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 4'b1001, 1'b0};
    run_vec(v, "mfhi2");

    // Backpressure: result held while OutReady is low, InValid pulses ignored.
    bus.OutReady = 1'b0;
    send(2'b10, 6'b100000, 32'd10, 32'd20);
    check("bp_outvalid0", bus.OutValid, 1);
    check("bp_result0",   bus.Result,   30);
    for (int i = 0; i < 5; i++) begin
      bus.InValid  = 1'b1;
      bus.ALUOp    = 2'b01;
      bus.FuncCode = 6'b000000;
      bus.A        = 32'd99;
      bus.B        = 32'd1;
      @(posedge clk);
      @(negedge clk);
      bus.InValid  = 1'b0;
      check($sformatf("bp_outvalid_c%0d", i), bus.OutValid, 1);
      check($sformatf("bp_result_c%0d", i),   bus.Result,   30);
      check($sformatf("bp_aluctl_c%0d", i),   bus.ALUctl,   4'b0010);
      check($sformatf("bp_inready_c%0d", i),  bus.InReady,  0);
    end
    bus.OutReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_inready",  bus.InReady,  1);
    check("bp_release_outvalid", bus.OutValid, 0);
    check("bp_hi_kept", bus.Hi, 32'hFFFFFFFE);
    check("bp_lo_kept", bus.Lo, 32'h00000001);

    // Reset during MUL aborts the multiply and clears HI/LO.
    send(2'b10, 6'b011001, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_inready",  bus.InReady,  1);
    check("abort_outvalid", bus.OutValid, 0);
    check("abort_hi",       bus.Hi,       0);
    check("abort_lo",       bus.Lo,       0);
    check("abort_result",   bus.Result,   0);
    check("abort_zero",     bus.Zero,     1);
    ovs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.OutValid === 1'b1) ovs++;
    end
    check("abort_no_outvalid", ovs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
